// File: rtl/systolic_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_if
// Stream bundle between the layer scheduler / DMA side and the systolic
// array sequencer: weight-row stream, activation stream, result stream.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface systolic_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  logic            w_valid;
  logic            w_ready;
  logic [N*DW-1:0] w_data;
  logic            a_valid;
  logic            a_ready;
  logic [N*DW-1:0] a_data;
  logic            out_valid;
  logic [N*DW-1:0] out_data;

  // Scheduler / DMA side
  modport master (
    output w_valid, w_data, a_valid, a_data,
    input  w_ready, a_ready, out_valid, out_data
  );

  // Sequencer side
  modport slave (
    input  w_valid, w_data, a_valid, a_data,
    output w_ready, a_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for an NxN weight-stationary systolic array: loads one weight
// row per beat, streams activation vectors with per-row skew, deskews the
// bottom-edge partial sums into aligned result vectors, flags job end.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_ctrl #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cfg_fp16,
  input  logic            cfg_signed,
  input  logic [CNTW-1:0] cfg_num_vec,
  systolic_ctrl_if.slave  s,
  output logic            pe_mode_fp16,
  output logic            pe_signed,
  output logic [N-1:0]    pe_load_b,
  output logic [N*DW-1:0] pe_b,
  output logic [N*DW-1:0] pe_a,
  output logic [N*DW-1:0] pe_c_top,
  input  logic [N*DW-1:0] pe_c_bot,
  output logic            busy,
  output logic            done
);

  localparam int LCW = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = $clog2(2 * N) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state;
  logic [CNTW-1:0] num_vec;
  logic [CNTW-1:0] acc_cnt;
  logic [LCW-1:0]  load_cnt;
  logic [DCW-1:0]  drain_cnt;
  logic            w_fire;
  logic            a_fire;
  logic [N*DW-1:0] push_data;
  logic [N*DW-1:0] deskew_data;
  logic [2*N-2:0]  vline;
  logic            out_valid_q;
  logic [N*DW-1:0] out_data_q;

  assign s.w_ready = (state == S_LOAD);
  assign s.a_ready = (state == S_RUN) && (acc_cnt < num_vec);
  assign w_fire    = s.w_valid & s.w_ready;
  assign a_fire    = s.a_valid & s.a_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign pe_c_top  = '0;
  assign pe_b      = w_fire ? s.w_data : '0;
  // Bubbles and all non-RUN cycles push zero into the skew line
  assign push_data = a_fire ? s.a_data : '0;

  // One-hot row strobe only on an accepted weight beat
  always_comb begin
    pe_load_b = '0;
    if (w_fire) pe_load_b[load_cnt] = 1'b1;
  end

  // Job sequencing and configuration latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      num_vec      <= '0;
      acc_cnt      <= '0;
      load_cnt     <= '0;
      drain_cnt    <= '0;
      pe_mode_fp16 <= 1'b0;
      pe_signed    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pe_mode_fp16 <= cfg_fp16;
            pe_signed    <= cfg_signed;
            num_vec      <= cfg_num_vec;
            acc_cnt      <= '0;
            load_cnt     <= '0;
            drain_cnt    <= '0;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_fire) begin
            if (load_cnt == LCW'(N - 1)) begin
              state <= (num_vec == '0) ? S_DONE : S_RUN;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (a_fire) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == num_vec - CNTW'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DCW'(2 * N - 1)) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Input skew: row i sees its word i+1 cycles after the push
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DW-1:0] sr [0:gi];

    // Per-row shift register of depth i+1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= gi; k++) sr[k] <= '0;
      end else begin
        sr[0] <= push_data[gi*DW +: DW];
        for (int k = 1; k <= gi; k++) sr[k] <= sr[k-1];
      end
    end

    assign pe_a[gi*DW +: DW] = sr[gi];
  end

  // Output deskew: column j waits N-1-j cycles so all columns line up
  for (genvar gj = 0; gj < N; gj++) begin : g_deskew
    if (N - 1 - gj > 0) begin : g_dly
      logic [DW-1:0] dl [0:N-2-gj];

      // Column delay line
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k <= N - 2 - gj; k++) dl[k] <= '0;
        end else begin
          dl[0] <= pe_c_bot[gj*DW +: DW];
          for (int k = 1; k <= N - 2 - gj; k++) dl[k] <= dl[k-1];
        end
      end

      assign deskew_data[gj*DW +: DW] = dl[N-2-gj];
    end else begin : g_pass
      assign deskew_data[gj*DW +: DW] = pe_c_bot[gj*DW +: DW];
    end
  end

  // Valid tracking and the shared output register; valid lands 2N after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vline       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      vline       <= {vline[2*N-3:0], a_fire};
      out_valid_q <= vline[2*N-2];
      out_data_q  <= deskew_data;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl
// Scoreboard bench: stimulus pushes hand-computed result vectors with their
// due cycle, a monitor pops them whenever out_valid is seen. A behavioural
// wavefront model of the PE array closes the loop from pe_a to pe_c_bot.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_systolic_ctrl;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int CNTW = 16;
  localparam int LAT  = 8;

  typedef logic [N*DW-1:0] mat_t [N];
  typedef struct {
    logic [N*DW-1:0] data;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            cfg_fp16 = 1'b0;
  logic            cfg_signed = 1'b0;
  logic [CNTW-1:0] cfg_num_vec = '0;
  logic            pe_mode_fp16, pe_signed, busy, done;
  logic [N-1:0]    pe_load_b;
  logic [N*DW-1:0] pe_b, pe_a, pe_c_top;
  logic [N*DW-1:0] pe_c_bot;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  systolic_ctrl_if #(.N(N), .DW(DW)) bus ();

  systolic_ctrl #(.N(N), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_fp16(cfg_fp16),
    .cfg_signed(cfg_signed), .cfg_num_vec(cfg_num_vec), .s(bus),
    .pe_mode_fp16(pe_mode_fp16), .pe_signed(pe_signed), .pe_load_b(pe_load_b),
    .pe_b(pe_b), .pe_a(pe_a), .pe_c_top(pe_c_top), .pe_c_bot(pe_c_bot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- PE array model ----------------
  logic [N*DW-1:0] wm [N];
  logic [N*DW-1:0] hq [0:2*N-2];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (pe_load_b[i]) wm[i] <= pe_b;
    hq[0] <= pe_a;
    for (int k = 1; k <= 2 * N - 2; k++) hq[k] <= hq[k-1];
  end

  function automatic real bf2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(h[6:0]) / 128.0;
    e = int'(h[14:7]) - 127;
    m = m * (2.0 ** e);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] b;
    int          e;
    if (r == 0.0) return 16'h0000;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:45]};
  endfunction

  // Column j at cycle t sums row i's input that sat on pe_a j+N-1-i cycles ago
  always_comb begin
    pe_c_bot = '0;
    for (int j = 0; j < N; j++) begin
      longint      isum;
      real         rsum;
      logic [15:0] av, wv;
      isum = 0;
      rsum = 0.0;
      for (int i = 0; i < N; i++) begin
        int d;
        d = j + N - 1 - i;
        if (d == 0) av = pe_a[i*DW +: DW];
        else        av = hq[d-1][i*DW +: DW];
        wv = wm[i][j*DW +: DW];
        if (pe_mode_fp16) rsum = rsum + bf2r(wv) * bf2r(av);
        else if (pe_signed) isum = isum + longint'($signed(wv)) * longint'($signed(av));
        else isum = isum + longint'(wv) * longint'(av);
      end
      pe_c_bot[j*DW +: DW] = pe_mode_fp16 ? r2bf(rsum) : isum[DW-1:0];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every out_valid must match the oldest pending result
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d required none pending", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  function automatic logic [N*DW-1:0] pk(input int a0, a1, a2, a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic do_start(input logic fp, input logic sg, input int nv);
    @(negedge clk);
    start = 1'b1; cfg_fp16 = fp; cfg_signed = sg; cfg_num_vec = CNTW'(nv);
    @(negedge clk);
    start = 1'b0; cfg_fp16 = 1'b0; cfg_signed = 1'b0; cfg_num_vec = '0;
    chk("w_ready_after_start", 64'(bus.w_ready), 64'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("pe_mode_fp16", 64'(pe_mode_fp16), 64'(fp));
    chk("pe_signed", 64'(pe_signed), 64'(sg));
  endtask

  task automatic load_weights(input mat_t w, input int gap, output int t_last);
    t_last = 0;
    for (int k = 0; k < N; k++) begin
      repeat (gap) begin
        bus.w_valid = 1'b0;
        #1;
        chk("pe_load_b_gap", 64'(pe_load_b), 64'd0);
        chk("a_ready_in_load", 64'(bus.a_ready), 64'd0);
        @(negedge clk);
      end
      bus.w_valid = 1'b1;
      bus.w_data  = w[k];
      #1;
      chk("pe_load_b_beat", 64'(pe_load_b), 64'(1 << k));
      chk("pe_b_beat", pe_b, w[k]);
      chk("a_ready_in_load", 64'(bus.a_ready), 64'd0);
      t_last = cyc;
      @(negedge clk);
    end
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
  endtask

  task automatic send_vec(input logic [N*DW-1:0] v, input logic [N*DW-1:0] res,
                          input int bubbles, output int t_acc);
    int guard;
    repeat (bubbles) begin
      bus.a_valid = 1'b0;
      @(negedge clk);
    end
    bus.a_valid = 1'b1;
    bus.a_data  = v;
    guard = 0;
    while (!bus.a_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("a_ready_timeout", 64'd0, 64'd1);
    t_acc = cyc;
    q.push_back('{data: res, cyc: cyc + LAT});
    @(negedge clk);
  endtask

  task automatic wait_done(input int exp_cyc);
    int guard;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("done_cycle", 64'(cyc), 64'(exp_cyc));
    chk("sb_drained", 64'(q.size()), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_w_ready"}, 64'(bus.w_ready), 64'd0);
    chk({tag, "_a_ready"}, 64'(bus.a_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"}, bus.out_data, 64'd0);
    chk({tag, "_pe_load_b"}, 64'(pe_load_b), 64'd0);
    chk({tag, "_pe_a"}, pe_a, 64'd0);
    chk({tag, "_pe_b"}, pe_b, 64'd0);
    chk({tag, "_pe_c_top"}, pe_c_top, 64'd0);
    chk({tag, "_pe_mode"}, 64'({pe_mode_fp16, pe_signed}), 64'd0);
  endtask

  task automatic identity_job(input int bubbles);
    mat_t id;
    int   tl, ta;
    for (int k = 0; k < N; k++) id[k] = 64'(1) << (16 * k);
    do_start(1'b0, 1'b0, 3);
    load_weights(id, 0, tl);
    send_vec(pk(1, 2, 3, 4), pk(1, 2, 3, 4), 0, ta);
    send_vec(pk(5, 6, 7, 8), pk(5, 6, 7, 8), bubbles, ta);
    send_vec(pk(9, 10, 11, 12), pk(9, 10, 11, 12), bubbles, ta);
    bus.a_valid = 1'b0;
    chk("a_ready_after_last", 64'(bus.a_ready), 64'd0);
    wait_done(ta + LAT + 1);
  endtask

  initial begin
    mat_t ones, fpw;
    int   tl, ta, guard;
    bus.w_valid = 1'b0; bus.w_data = '0;
    bus.a_valid = 1'b0; bus.a_data = '0;
    for (int k = 0; k < N; k++) begin
      ones[k] = pk(1, 1, 1, 1);
      fpw[k]  = {4{16'h3F80}};
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Abort mid-RUN by reset, then a clean job
    do_start(1'b1, 1'b1, 3);
    load_weights(ones, 0, tl);
    send_vec(pk(1, 2, 3, 4), pk(10, 10, 10, 10), 0, ta);
    bus.a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", 64'(done), 64'd0);

    // int8 identity, back-to-back
    identity_job(0);

    // Bubbles between vectors
    identity_job(2);

    // fp16 job: 4 x (1.0 * 2.0) = 8.0 per column
    do_start(1'b1, 1'b0, 1);
    load_weights(fpw, 0, tl);
    send_vec({4{16'h4000}}, {4{16'h4100}}, 0, ta);
    bus.a_valid = 1'b0;
    wait_done(ta + LAT + 1);
    chk("fp_mode_held", 64'(pe_mode_fp16), 64'd1);

    // Weight backpressure with an all-ones matrix: each column sums the vector
    do_start(1'b0, 1'b0, 2);
    load_weights(ones, 1, tl);
    chk("a_ready_after_load", 64'(bus.a_ready), 64'd1);
    send_vec(pk(1, 2, 3, 4), pk(10, 10, 10, 10), 0, ta);
    send_vec(pk(100, 0, 7, 65535), pk(106, 106, 106, 106), 1, ta);
    bus.a_valid = 1'b0;
    wait_done(ta + LAT + 1);

    // num_vec = 0, with a start pulse while busy
    do_start(1'b0, 1'b0, 0);
    bus.a_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_busy", 64'(bus.w_ready), 64'd1);
    load_weights(ones, 0, tl);
    chk("nv0_a_ready", 64'(bus.a_ready), 64'd0);
    wait_done(tl + 1);
    bus.a_valid = 1'b0;
    guard = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) guard++;
    end
    chk("idle_after_nv0", 64'(guard), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
